// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the data-side memory system.
//   - region bases for the data RAM and the peripheral window
//   - peripheral register offsets (low address byte)
//   - STATUS bit positions
//   - default parameter values and register reset values
package mmio_pkg;

   localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
   localparam logic [31:0] MMIO_BASE = 32'h0000_FF00;

   localparam logic [7:0] OFF_CONSOLE_DATA = 8'h00;
   localparam logic [7:0] OFF_STATUS       = 8'h04;
   localparam logic [7:0] OFF_TIMER        = 8'h08;
   localparam logic [7:0] OFF_TIMER_CMP    = 8'h0C;

   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_HIT     = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 8;

   localparam int DEF_RAM_WORDS  = 64;
   localparam int DEF_FIFO_DEPTH = 8;

   localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/data_mem_mmio_tx_fifo.sv
// tx_fifo: console transmit FIFO, power-of-2 depth.
//   clk, reset  : clock and synchronous active-high reset (empties the FIFO)
//   push        : write push_data; ignored when full
//   pop         : consume the head entry; ignored when empty
//   head        : current head entry, forced to 0 while empty
//   count       : number of stored entries (0..FIFO_DEPTH)
//   full, empty : occupancy flags
module tx_fifo
   import mmio_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int WIDTH      = 8,
   localparam int PW        = $clog2(FIFO_DEPTH),
   localparam int CW        = PW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign count   = count_q;
   // Gating the head keeps tx_data at 0 whenever nothing is queued.
   assign head    = empty ? '0 : mem_q[rd_ptr_q];

   // Pointers are exactly PW bits wide, so wrap is the natural overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // Storage is not reset; the reset pointers make stale entries invisible.
   always_ff @(posedge clk) begin
      if (push_ok && !reset) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: data RAM plus console FIFO and cycle timer behind one port.
//   clk, reset        : clock, synchronous active-high reset
//   memwrite          : store strobe
//   addr, wdata       : byte address (bits 1:0 ignored) and store data
//   rdata             : combinational load data (pre-write state)
//   tx_data, tx_valid : FIFO head byte / non-empty
//   tx_ready          : sink accepts the head this cycle
//   timer_irq         : sticky timer-hit flag
module data_mem_mmio
   import mmio_pkg::*;
#(
   parameter int RAM_WORDS  = DEF_RAM_WORDS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        timer_irq
);

   localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0] ram_q [RAM_WORDS];
   logic [31:0] timer_q, timer_d, cmp_q, cmp_d;
   logic        hit_q, hit_d, ovf_q, ovf_d;

   logic          ram_sel, mmio_sel;
   logic [7:0]    off;
   logic [AW-1:0] ram_idx;
   logic          wr_console, wr_status, wr_timer, wr_cmp;
   logic          fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [31:0]   status_word;
   logic          unused_addr;

   assign ram_sel  = (addr[31:8] == RAM_BASE[31:8]);
   assign mmio_sel = (addr[31:8] == MMIO_BASE[31:8]);
   assign off      = addr[7:0];
   assign ram_idx  = addr[2 +: AW];
   assign unused_addr = ^addr[1:0];

   assign wr_console = memwrite && mmio_sel && (off == OFF_CONSOLE_DATA);
   assign wr_status  = memwrite && mmio_sel && (off == OFF_STATUS);
   assign wr_timer   = memwrite && mmio_sel && (off == OFF_TIMER);
   assign wr_cmp     = memwrite && mmio_sel && (off == OFF_TIMER_CMP);

   assign tx_valid  = !fifo_empty;
   assign fifo_pop  = tx_valid && tx_ready;
   assign timer_irq = hit_q;

   tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (wr_console),
      .push_data (wdata[7:0]),
      .pop       (fifo_pop),
      .head      (tx_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (memwrite && ram_sel && !reset) ram_q[ram_idx] <= wdata;
   end

   // In both sticky flags the set term is applied last so it beats W1C.
   always_comb begin
      timer_d = timer_q + 32'd1;
      if (wr_timer) timer_d = wdata;
      cmp_d = cmp_q;
      if (wr_cmp) cmp_d = wdata;
      hit_d = hit_q;
      if (wr_status && wdata[ST_HIT]) hit_d = 1'b0;
      if (timer_q == cmp_q)           hit_d = 1'b1;
      ovf_d = ovf_q;
      if (wr_status && wdata[ST_OVF]) ovf_d = 1'b0;
      if (wr_console && fifo_full)    ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
         cmp_q   <= TIMER_CMP_RST;
         hit_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         timer_q <= timer_d;
         cmp_q   <= cmp_d;
         hit_q   <= hit_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      status_word           = '0;
      status_word[ST_EMPTY] = fifo_empty;
      status_word[ST_FULL]  = fifo_full;
      status_word[ST_HIT]   = hit_q;
      status_word[ST_OVF]   = ovf_q;
      status_word[ST_CNT_LSB +: 8] = 8'(fifo_count);
   end

   always_comb begin
      rdata = '0;
      if (ram_sel) begin
         rdata = ram_q[ram_idx];
      end else if (mmio_sel) begin
         case (off)
            OFF_STATUS:    rdata = status_word;
            OFF_TIMER:     rdata = timer_q;
            OFF_TIMER_CMP: rdata = cmp_q;
            default:       rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_mmio.sv
module tb_data_mem_mmio;

   localparam int RAM_WORDS  = 64;
   localparam int FIFO_DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memwrite = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        timer_irq;

   data_mem_mmio #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .timer_irq (timer_irq)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;
   bit chk_en = 1'b0;

   // Behavioural model: plain arrays, a queue and scalars.
   logic [31:0] m_ram [RAM_WORDS];
   bit          m_ram_ok [RAM_WORDS];
   logic [7:0]  m_q [$];
   logic [31:0] m_timer, m_cmp;
   bit          m_hit, m_ovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      else
         pass_cnt++;
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = 32'd0;
      s[0] = (m_q.size() == 0);
      s[1] = (m_q.size() == FIFO_DEPTH);
      s[2] = m_hit;
      s[3] = m_ovf;
      s[15:8] = 8'(m_q.size());
      return s;
   endfunction

   // Model state update on each rising edge from the pre-edge state.
   always @(posedge clk) begin
      if (reset) begin
         m_q.delete();
         m_timer = 32'd0;
         m_cmp   = 32'hFFFF_FFFF;
         m_hit   = 1'b0;
         m_ovf   = 1'b0;
      end else begin
         bit is_mmio, do_pop, do_push, was_full, match;
         is_mmio  = memwrite && (addr[31:8] == 24'h0000FF);
         do_pop   = (m_q.size() != 0) && tx_ready;
         do_push  = is_mmio && (addr[7:0] == 8'h00);
         was_full = (m_q.size() == FIFO_DEPTH);
         match    = (m_timer == m_cmp);
         if (is_mmio && addr[7:0] == 8'h04 && wdata[2]) m_hit = 1'b0;
         if (is_mmio && addr[7:0] == 8'h04 && wdata[3]) m_ovf = 1'b0;
         if (match) m_hit = 1'b1;
         if (do_push && was_full) m_ovf = 1'b1;
         if (is_mmio && addr[7:0] == 8'h08) m_timer = wdata;
         else                               m_timer = m_timer + 1;
         if (is_mmio && addr[7:0] == 8'h0C) m_cmp = wdata;
         if (do_pop) void'(m_q.pop_front());
         if (do_push && !was_full) m_q.push_back(wdata[7:0]);
         if (memwrite && addr[31:8] == 24'd0) begin
            m_ram[addr[7:2] % RAM_WORDS]    = wdata;
            m_ram_ok[addr[7:2] % RAM_WORDS] = 1'b1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [31:0] exp_rd;
         bit          rd_known;
         rd_known = 1'b1;
         exp_rd   = 32'd0;
         if (addr[31:8] == 24'd0) begin
            rd_known = m_ram_ok[addr[7:2] % RAM_WORDS];
            exp_rd   = m_ram[addr[7:2] % RAM_WORDS];
         end else if (addr[31:8] == 24'h0000FF) begin
            case (addr[7:0])
               8'h04:   exp_rd = m_status();
               8'h08:   exp_rd = m_timer;
               8'h0C:   exp_rd = m_cmp;
               default: exp_rd = 32'd0;
            endcase
         end
         check("cyc_tx_valid", {31'd0, tx_valid}, {31'd0, m_q.size() != 0});
         check("cyc_tx_data", {24'd0, tx_data}, {24'd0, (m_q.size() != 0) ? m_q[0] : 8'h00});
         check("cyc_timer_irq", {31'd0, timer_irq}, {31'd0, m_hit});
         if (rd_known) check("cyc_rdata", rdata, exp_rd);
      end
   end

   task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
      memwrite = we; addr = a; wdata = d;
      @(posedge clk); #1;
   endtask

   task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
      memwrite = 1'b0; addr = a;
      #1;
      check(name, rdata, exp);
   endtask

   initial begin
      for (int i = 0; i < RAM_WORDS; i++) m_ram_ok[i] = 1'b0;

      // Reset
      reset = 1'b1;
      cyc(1'b0, 32'h0, 32'h0);
      cyc(1'b0, 32'h0, 32'h0);
      reset = 1'b0;
      chk_en = 1'b1;
      peek("rst_status", 32'h0000_FF04, 32'h0000_0001);
      peek("rst_cmp", 32'h0000_FF0C, 32'hFFFF_FFFF);
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);

      // RAM store/load and unmapped decode
      cyc(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      peek("ram_load", 32'h0000_0010, 32'hDEAD_BEEF);
      peek("unmapped_load", 32'h0000_1000, 32'h0);
      cyc(1'b1, 32'h0000_1010, 32'h1234_5678);
      peek("unmapped_store_ignored", 32'h0000_0010, 32'hDEAD_BEEF);
      cyc(1'b1, 32'h0000_0013, 32'hCAFE_F00D);
      peek("ram_low_bits_ignored", 32'h0000_0010, 32'hCAFE_F00D);

      // Three pushes then drain
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h0000_FF00, 32'h41 + i);
      peek("three_status", 32'h0000_FF04, 32'h0000_0300);
      check("three_head", {24'd0, tx_data}, 32'h41);
      peek("console_read_zero", 32'h0000_FF00, 32'h0);
      tx_ready = 1'b1;
      addr = 32'h0000_FF04;
      for (int i = 0; i < 3; i++) begin
         check("drain_byte", {24'd0, tx_data}, 32'h41 + i);
         cyc(1'b0, 32'h0000_FF04, 32'h0);
      end
      tx_ready = 1'b0;
      check("drain_empty_valid", {31'd0, tx_valid}, 32'd0);
      peek("drain_status", 32'h0000_FF04, 32'h0000_0001);

      // Overflow
      for (int i = 0; i < FIFO_DEPTH + 1; i++) cyc(1'b1, 32'h0000_FF00, 32'h50 + i);
      peek("ovf_status", 32'h0000_FF04, 32'h0000_080A);
      cyc(1'b1, 32'h0000_FF04, 32'h8);
      peek("ovf_cleared", 32'h0000_FF04, 32'h0000_0802);
      tx_ready = 1'b1;
      cyc(1'b1, 32'h0000_FF00, 32'h99);
      tx_ready = 1'b0;
      peek("push_pop_full", 32'h0000_FF04, 32'h0000_0708);
      tx_ready = 1'b1;
      for (int i = 1; i < FIFO_DEPTH; i++) begin
         check("ovf_drain_byte", {24'd0, tx_data}, 32'h50 + i);
         cyc(1'b0, 32'h0000_FF04, 32'h0);
      end
      tx_ready = 1'b0;
      check("ovf_drain_done", {31'd0, tx_valid}, 32'd0);
      cyc(1'b1, 32'h0000_FF04, 32'h8);

      // Timer wrap and compare
      cyc(1'b1, 32'h0000_FF08, 32'hFFFF_FFFE);
      cyc(1'b1, 32'h0000_FF0C, 32'h0000_0001);
      peek("timer_pre_wrap", 32'h0000_FF08, 32'hFFFF_FFFF);
      cyc(1'b0, 32'h0000_FF08, 32'h0);
      peek("timer_wrapped", 32'h0000_FF08, 32'h0);
      check("irq_wrap0", {31'd0, timer_irq}, 32'd0);
      cyc(1'b0, 32'h0000_FF08, 32'h0);
      check("irq_wrap1", {31'd0, timer_irq}, 32'd0);
      cyc(1'b0, 32'h0000_FF08, 32'h0);
      check("irq_wrap2", {31'd0, timer_irq}, 32'd1);
      cyc(1'b1, 32'h0000_FF04, 32'h4);
      check("irq_w1c", {31'd0, timer_irq}, 32'd0);
      cyc(1'b1, 32'h0000_FF08, 32'd10);
      cyc(1'b1, 32'h0000_FF0C, 32'd12);
      cyc(1'b0, 32'h0000_FF08, 32'h0);
      peek("timer_at_cmp", 32'h0000_FF08, 32'd12);
      cyc(1'b1, 32'h0000_FF04, 32'h4);
      check("irq_set_wins", {31'd0, timer_irq}, 32'd1);
      cyc(1'b1, 32'h0000_FF04, 32'h4);
      check("irq_cleared", {31'd0, timer_irq}, 32'd0);

      // Reset mid-operation
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'h0000_FF00, 32'h60 + i);
      peek("pre_reset_status", 32'h0000_FF04, 32'h0000_0400);
      reset = 1'b1;
      cyc(1'b1, 32'h0000_FF00, 32'h77);
      reset = 1'b0;
      check("post_reset_valid", {31'd0, tx_valid}, 32'd0);
      peek("post_reset_status", 32'h0000_FF04, 32'h0000_0001);
      peek("post_reset_timer", 32'h0000_FF08, 32'h0);
      cyc(1'b0, 32'h0000_FF08, 32'h0);
      peek("post_reset_timer_inc", 32'h0000_FF08, 32'h1);
      cyc(1'b0, 32'h0000_0000, 32'h0);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-side memory system for the single-cycle MIPS core. Sits directly downstream of the core's data port, taking the store strobe, the ALU-computed address and the store data. It returns load data in the same cycle. It combines a word-addressed data RAM with a small memory-mapped peripheral region: a console TX FIFO with a valid/ready sink and a free-running cycle timer with a compare flag.

## Interface
Parameters:
- RAM_WORDS, 64, data RAM depth in 32-bit words; power of 2, at most 64.
- FIFO_DEPTH, 8, console FIFO entries; power of 2, from 2 to 128.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- memwrite  input  1  store strobe from the core.
- addr  input  32  byte address (core aluout); addr[1:0] ignored.
- wdata  input  32  store data (core writedata).
- rdata  output  32  load data (core readdata), combinational.
- tx_data  output  8  FIFO head byte.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  sink accepts head this cycle.
- timer_irq  output  1  mirror of the sticky timer-hit flag.

## Operation
- Address decode uses the full 32 bits:
  - RAM when addr[31:8]==0; word index is addr[7:2], truncated to the RAM_WORDS range.
  - MMIO when addr[31:8]==24'h0000FF.
  - All other addresses are unmapped: reads return 0 and writes are ignored.
- MMIO register map, by addr[7:0]:
  - 0x00 CONSOLE_DATA. A write pushes wdata[7:0]. A read returns 0.
  - 0x04 STATUS (read):
    - bit0 empty
    - bit1 full
    - bit2 timer_hit
    - bit3 overflow
    - [15:8] FIFO count
    - other bits 0
  - 0x04 STATUS (write): write-1-to-clear on bits 2 and 3 only.
  - 0x08 TIMER. Read or write the counter.
  - 0x0C TIMER_CMP. Read or write the compare value.
  - Other offsets read 0 and ignore writes.
- RAM: a write stores the full word at the edge when memwrite is asserted and the address is in range. No byte enables.
- FIFO:
  - A push is accepted only if count < FIFO_DEPTH at the start of the cycle. A push into a full FIFO is dropped and sets overflow, even if a pop happens in the same cycle.
  - A pop occurs when tx_valid && tx_ready.
  - A simultaneous push and pop on a non-full FIFO leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Timer:
  - Increments by 1 every cycle, wrapping 0xFFFF_FFFF to 0.
  - A write to TIMER loads wdata in place of the increment.
- Compare:
  - If timer == cmp at the start of a cycle, timer_hit is set at that edge.
  - If a set and a W1C clear land in the same cycle, the set wins.
  - A write to TIMER_CMP takes effect for the compare in the next cycle.

## Timing
- rdata is purely combinational from addr and the current register/RAM state. It reflects values before the current cycle's write: no write-to-read bypass.
- Store and push effects are visible to reads in the cycle after the edge.
- Push to tx: a byte pushed into an empty FIFO appears on tx_valid/tx_data in the next cycle.
- tx_data must remain stable while tx_valid && !tx_ready.
- Reset values, applied at the first edge with reset high:
  - FIFO empty; count 0; tx_valid 0; tx_data 0.
  - timer 0; cmp 0xFFFF_FFFF.
  - timer_hit 0; overflow 0; timer_irq 0.
- RAM contents are not reset and are undefined after reset.
- Reset asserted mid-operation discards all FIFO contents immediately. It overrides any push, pop or write in the same cycle.

## Structure
- Package mmio_pkg holds:
  - region base constants (RAM base 0, MMIO base 32'h0000_FF00)
  - register offsets (CONSOLE_DATA, STATUS, TIMER, TIMER_CMP)
  - STATUS bit-index constants
  - default parameter values
- Sub-module tx_fifo (params FIFO_DEPTH, width 8):
  - ports: push, push_data, pop, head, count, full, empty
  - owns the overflow-free FIFO logic
- The top level owns decode, RAM, timer, flags and the read mux.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10 and load 0x10 the next cycle -> rdata=0xDEADBEEF. Load 0x1000 (unmapped) -> rdata=0.
- With tx_ready=0, push 0x41, 0x42, 0x43 -> STATUS reads 0x0000_0300 and tx_data=0x41. Then raise tx_ready for 3 cycles -> bytes 0x41, 0x42, 0x43 in order, then tx_valid=0 and STATUS=0x0000_0001.
- With tx_ready=0, push FIFO_DEPTH+1 bytes -> count=FIFO_DEPTH, full=1, overflow=1, and the last byte is not in the FIFO. Write STATUS with 0x8 -> overflow=0.
- Push to a full FIFO in the same cycle as a pop -> count drops by 1 and overflow sets.
- Write TIMER=0xFFFF_FFFE and TIMER_CMP=0x0000_0001 -> timer wraps to 0, then timer_irq=1 two cycles after the wrap. Write STATUS 0x4 -> cleared, unless the timer matches cmp in that cycle.
- Assert reset with 4 bytes queued and timer nonzero -> next cycle tx_valid=0, STATUS=0x0000_0001 and TIMER reads 0 or 1 (incrementing after reset is released).
